// File: rtl/ita_serial_divider.sv
// Restoring serial divider for one softmax row sum.
// Computes floor(Dividend / D) one quotient bit per clock and returns it
// saturated to OutWidth bits over a valid/ready handshake.
// One division is in flight at a time. All outputs come straight from flops.
module ita_serial_divider #(
   parameter int unsigned DivisorWidth  = 19,
   parameter int unsigned OutWidth      = 11,
   parameter int unsigned DividendWidth = 17,
   parameter int unsigned Dividend      = 65536
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic                    clear_i,
   input  logic                    in_valid_i,
   output logic                    in_ready_o,
   input  logic [DivisorWidth-1:0] in_data_i,
   output logic                    out_valid_o,
   input  logic                    out_ready_i,
   output logic [OutWidth-1:0]     out_data_o,
   output logic                    busy_o
);

   // One extra bit keeps {R, bit} from overflowing, since R < D always holds.
   localparam int unsigned RemWidth = DivisorWidth + 1;
   localparam int unsigned CntWidth = (DividendWidth > 1) ? $clog2(DividendWidth) : 1;

   localparam logic [DividendWidth-1:0] DividendVal = DividendWidth'(Dividend);
   localparam logic [DividendWidth-1:0] OutMax      =
      DividendWidth'((64'd1 << OutWidth) - 64'd1);
   localparam logic [CntWidth-1:0]      CntStart    = CntWidth'(DividendWidth - 1);

   typedef enum logic [1:0] {
      StIdle,
      StCalc,
      StDone
   } state_e;

   state_e                   state_q;
   logic [DivisorWidth-1:0]  divisor_q;
   logic [RemWidth-1:0]      rem_q;
   logic [DividendWidth-1:0] quo_q;
   logic [CntWidth-1:0]      cnt_q;
   logic                     in_ready_q;
   logic                     out_valid_q;
   logic [OutWidth-1:0]      out_data_q;
   logic                     busy_q;

   logic                     dividend_bit;
   logic [RemWidth-1:0]      rem_shift;
   logic [RemWidth-1:0]      divisor_ext;
   logic                     rem_ge;
   logic [RemWidth-1:0]      rem_step;
   logic [DividendWidth-1:0] quo_step;
   logic [OutWidth-1:0]      out_sat;

   // One restoring step, plus the saturated quotient as it will look after this step.
   always_comb begin
      dividend_bit = DividendVal[cnt_q];
      rem_shift    = {rem_q[RemWidth-2:0], dividend_bit};
      divisor_ext  = {1'b0, divisor_q};
      rem_ge       = (rem_shift >= divisor_ext);
      rem_step     = rem_ge ? (rem_shift - divisor_ext) : rem_shift;
      quo_step     = quo_q;
      quo_step[cnt_q] = rem_ge;
      out_sat      = (quo_step > OutMax) ? {OutWidth{1'b1}} : quo_step[OutWidth-1:0];
   end

   // Control FSM and datapath registers; rst_i and clear_i abort everything.
   always_ff @(posedge clk_i) begin
      if (rst_i || clear_i) begin
         state_q     <= StIdle;
         divisor_q   <= '0;
         rem_q       <= '0;
         quo_q       <= '0;
         cnt_q       <= '0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         busy_q      <= 1'b0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (in_valid_i) begin
                  divisor_q  <= in_data_i;
                  rem_q      <= '0;
                  quo_q      <= '0;
                  cnt_q      <= CntStart;
                  state_q    <= StCalc;
                  in_ready_q <= 1'b0;
                  busy_q     <= 1'b1;
               end
            end
            StCalc: begin
               rem_q <= rem_step;
               quo_q <= quo_step;
               if (cnt_q == '0) begin
                  state_q     <= StDone;
                  out_valid_q <= 1'b1;
                  out_data_q  <= out_sat;
               end else begin
                  cnt_q <= cnt_q - 1'b1;
               end
            end
            StDone: begin
               // Result holds until taken; ready for a new divisor only afterwards.
               if (out_ready_i) begin
                  state_q     <= StIdle;
                  out_valid_q <= 1'b0;
                  in_ready_q  <= 1'b1;
                  busy_q      <= 1'b0;
               end
            end
            default: begin
               state_q     <= StIdle;
               in_ready_q  <= 1'b1;
               out_valid_q <= 1'b0;
               busy_q      <= 1'b0;
            end
         endcase
      end
   end

   assign in_ready_o  = in_ready_q;
   assign out_valid_o = out_valid_q;
   assign out_data_o  = out_data_q;
   assign busy_o      = busy_q;

   // A stalled result must neither drop nor change.
   property p_out_hold;
      @(posedge clk_i) (out_valid_o && !out_ready_i && !rst_i && !clear_i)
         |=> (out_valid_o && $stable(out_data_o));
   endproperty
   a_out_hold: assert property (p_out_hold);

   // Input and output handshakes are mutually exclusive.
   property p_excl;
      @(posedge clk_i) !(in_ready_o && out_valid_o);
   endproperty
   a_excl: assert property (p_excl);

endmodule
